wb_rr_arbiter: RTL

WB_RR_ARBITER -- requirements
Module: wb_rr_arbiter

---
 rtl/wb_arb_pkg.sv | 15 +
 rtl/rr_priority_picker.sv | 27 ++
 rtl/wb_rr_arbiter.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/wb_arb_pkg.sv
// Shared types and sizing helpers for the Wishbone round-robin arbiter.
package wb_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_OWNED = 2'd1,
    ARB_ABORT = 2'd2
  } arb_state_e;

  // Bits needed to hold every value from 0 up to and including max_val.
  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational round-robin picker: one-hot winner among req, searched
// starting one position past last_ptr and wrapping around.
module rr_priority_picker #(
  parameter int NUM_REQ = 2,
  parameter int PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   last_ptr,
  output logic [NUM_REQ-1:0] gnt
);

  // Walk the ring from last_ptr+1; the first active request wins.
  always_comb begin
    logic found;
    gnt   = '0;
    found = 1'b0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      for (int j = 0; j < NUM_REQ; j++) begin
        if (!found && req[j] && (j == ((int'(last_ptr) + i) % NUM_REQ))) begin
          gnt[j] = 1'b1;
          found  = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/wb_rr_arbiter.sv
// Round-robin arbiter letting several pipelined Wishbone masters share one
// subordinate. A master keeps the bus until it drops cyc; a stuck transfer
// is aborted with err after TIMEOUT_CYCLES ack-less cycles.
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   ARB_IDLE  | no owner; bus quiet; picks next owner when any cyc is high
//   ARB_OWNED | grant held; owner's request routed to the subordinate
//   ARB_ABORT | one cycle: bus dropped, err pulsed to the owner
module wb_rr_arbiter
  import wb_arb_pkg::*;
#(
  parameter int NUM_MASTERS         = 2,
  parameter int WB_ADDRESS_WIDTH    = 32,
  parameter int WB_DATA_WIDTH       = 32,
  parameter int WB_DATA_GRANULARITY = 8,
  parameter int WB_SEL_WIDTH        = WB_DATA_WIDTH / WB_DATA_GRANULARITY,
  parameter int MAX_OUTSTANDING     = 8,
  parameter int TIMEOUT_CYCLES      = 255
) (
  input  logic                                    i_wb_clk,
  input  logic                                    i_wb_rst,
  input  logic [NUM_MASTERS-1:0]                  i_m_cyc,
  input  logic [NUM_MASTERS-1:0]                  i_m_stb,
  input  logic [NUM_MASTERS-1:0]                  i_m_we,
  input  logic [NUM_MASTERS*WB_ADDRESS_WIDTH-1:0] i_m_addr,
  input  logic [NUM_MASTERS*WB_DATA_WIDTH-1:0]    i_m_dat,
  input  logic [NUM_MASTERS*WB_SEL_WIDTH-1:0]     i_m_sel,
  output logic [WB_DATA_WIDTH-1:0]                o_m_dat,
  output logic [NUM_MASTERS-1:0]                  o_m_ack,
  output logic [NUM_MASTERS-1:0]                  o_m_stall,
  output logic [NUM_MASTERS-1:0]                  o_m_err,
  output logic                                    o_s_cyc,
  output logic                                    o_s_stb,
  output logic                                    o_s_we,
  output logic [WB_ADDRESS_WIDTH-1:0]             o_s_addr,
  output logic [WB_DATA_WIDTH-1:0]                o_s_dat,
  output logic [WB_SEL_WIDTH-1:0]                 o_s_sel,
  input  logic [WB_DATA_WIDTH-1:0]                i_s_dat,
  input  logic                                    i_s_ack,
  input  logic                                    i_s_stall,
  output logic [NUM_MASTERS-1:0]                  o_grant
);

  localparam int IDX_W = $clog2(NUM_MASTERS);
  localparam int OUT_W = cnt_width(MAX_OUTSTANDING);
  localparam int TO_W  = cnt_width(TIMEOUT_CYCLES);
  localparam logic [OUT_W-1:0] OUT_MAX = OUT_W'(MAX_OUTSTANDING);
  localparam logic [TO_W-1:0]  TO_MAX  = TO_W'(TIMEOUT_CYCLES);

  arb_state_e             state_q, state_d;
  logic [NUM_MASTERS-1:0] grant_q, grant_d;
  logic [IDX_W-1:0]       owner_q, owner_d;
  logic [IDX_W-1:0]       last_owner_q, last_owner_d;
  logic [OUT_W-1:0]       outstanding_q, outstanding_d;
  logic [TO_W-1:0]        timeout_q, timeout_d;

  logic [NUM_MASTERS-1:0] pick;
  logic [IDX_W-1:0]       pick_idx;
  logic                   own_cyc;
  logic                   own_stb;
  logic                   limit;
  logic                   fwd_ack;
  logic                   accept;

  rr_priority_picker #(
    .NUM_REQ (NUM_MASTERS),
    .PTR_W   (IDX_W)
  ) u_picker (
    .req      (i_m_cyc),
    .last_ptr (last_owner_q),
    .gnt      (pick)
  );

  // Convert the one-hot pick into an index for the owner register.
  always_comb begin
    pick_idx = '0;
    for (int k = 0; k < NUM_MASTERS; k++) begin
      if (pick[k]) pick_idx = IDX_W'(k);
    end
  end

  // Route the owner's slice of the request bus toward the subordinate.
  always_comb begin
    own_cyc  = 1'b0;
    own_stb  = 1'b0;
    o_s_we   = 1'b0;
    o_s_addr = '0;
    o_s_dat  = '0;
    o_s_sel  = '0;
    for (int k = 0; k < NUM_MASTERS; k++) begin
      if (owner_q == IDX_W'(k)) begin
        own_cyc  = i_m_cyc[k];
        own_stb  = i_m_stb[k];
        o_s_we   = i_m_we[k];
        o_s_addr = i_m_addr[k*WB_ADDRESS_WIDTH +: WB_ADDRESS_WIDTH];
        o_s_dat  = i_m_dat[k*WB_DATA_WIDTH +: WB_DATA_WIDTH];
        o_s_sel  = i_m_sel[k*WB_SEL_WIDTH +: WB_SEL_WIDTH];
      end
    end
  end

  // Bus qualifiers and per-master responses; only the granted master sees acks.
  always_comb begin
    limit     = (outstanding_q == OUT_MAX);
    fwd_ack   = 1'b0;
    o_s_cyc   = 1'b0;
    o_s_stb   = 1'b0;
    o_m_ack   = '0;
    o_m_err   = '0;
    o_m_stall = '1;
    if (state_q == ARB_OWNED) begin
      o_s_cyc   = own_cyc;
      o_s_stb   = own_cyc & own_stb & ~limit;
      fwd_ack   = i_s_ack & (outstanding_q != '0);
      o_m_ack   = grant_q & {NUM_MASTERS{fwd_ack}};
      o_m_stall = ~grant_q | {NUM_MASTERS{i_s_stall | limit}};
    end else if (state_q == ARB_ABORT) begin
      o_m_err = grant_q;
    end
  end

  assign accept  = o_s_stb & ~i_s_stall;
  assign o_m_dat = i_s_dat;
  assign o_grant = grant_q;

  // Ownership FSM with outstanding-transfer and ack-timeout tracking.
  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    owner_d       = owner_q;
    last_owner_d  = last_owner_q;
    outstanding_d = outstanding_q;
    timeout_d     = '0;
    case (state_q)
      ARB_IDLE: begin
        if (|i_m_cyc) begin
          state_d = ARB_OWNED;
          grant_d = pick;
          owner_d = pick_idx;
        end
      end
      ARB_OWNED: begin
        if (!own_cyc) begin
          state_d       = ARB_IDLE;
          grant_d       = '0;
          last_owner_d  = owner_q;
          outstanding_d = '0;
        end else begin
          if (accept && !fwd_ack) outstanding_d = outstanding_q + 1'b1;
          else if (!accept && fwd_ack) outstanding_d = outstanding_q - 1'b1;
          if ((outstanding_q != '0) && !fwd_ack) timeout_d = timeout_q + 1'b1;
          if (timeout_d == TO_MAX) begin
            state_d       = ARB_ABORT;
            outstanding_d = '0;
            timeout_d     = '0;
          end
        end
      end
      ARB_ABORT: begin
        state_d       = ARB_IDLE;
        grant_d       = '0;
        last_owner_d  = owner_q;
        outstanding_d = '0;
      end
      default: begin
        state_d       = ARB_IDLE;
        grant_d       = '0;
        outstanding_d = '0;
      end
    endcase
  end

  // State registers; reset leaves master 0 first in line.
  always_ff @(posedge i_wb_clk or posedge i_wb_rst) begin
    if (i_wb_rst) begin
      state_q       <= ARB_IDLE;
      grant_q       <= '0;
      owner_q       <= '0;
      last_owner_q  <= IDX_W'(NUM_MASTERS - 1);
      outstanding_q <= '0;
      timeout_q     <= '0;
    end else begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      owner_q       <= owner_d;
      last_owner_q  <= last_owner_d;
      outstanding_q <= outstanding_d;
      timeout_q     <= timeout_d;
    end
  end

endmodule
